// File: rtl/mtl_video_receiver.sv
// Sync-tracking receiver for an MTL-style LCD stream: counts HD/VD timing, locks onto it and
// presents active pixels with coordinates. Define MTL_RX_CHECKSUM_EN to add the oFrameSum output.
module mtl_video_receiver #(
  parameter int unsigned H_LINE  = 1056,
  parameter int unsigned V_LINE  = 525,
  parameter int unsigned H_BLANK = 46,
  parameter int unsigned H_FRONT = 210,
  parameter int unsigned V_BLANK = 23,
  parameter int unsigned V_FRONT = 22
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iHD,
  input  logic        iVD,
  input  logic [7:0]  iLCD_R,
  input  logic [7:0]  iLCD_G,
  input  logic [7:0]  iLCD_B,
  output logic        oPixValid,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  output logic [23:0] oPixel,
  output logic        oFrameStart,
  output logic        oFrameEnd,
  output logic        oLocked,
  output logic        oLineErr,
`ifdef MTL_RX_CHECKSUM_EN
  output logic        oFrameErr,
  output logic [31:0] oFrameSum
`else
  output logic        oFrameErr
`endif
);

  localparam logic [10:0] XLast  = 11'(H_LINE - 1);
  localparam logic [9:0]  YLast  = 10'(V_LINE - 1);
  localparam logic [10:0] XAct0  = 11'(H_BLANK);
  localparam logic [10:0] XAct1  = 11'(H_LINE - H_FRONT);
  localparam logic [9:0]  YAct0  = 10'(V_BLANK);
  localparam logic [9:0]  YAct1  = 10'(V_LINE - V_FRONT);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        hd_low, x_last, y_last;
  logic        line_err, frame_err, frame_ok;
  logic        act, first_px, last_px;
  logic [23:0] pix;

  assign hd_low = ~iHD;
  assign pix    = {iLCD_R, iLCD_G, iLCD_B};

  always_comb begin
    x_d    = hd_low ? 11'd0 : x_q + 11'd1;
    y_d    = y_q;
    if (hd_low) y_d = iVD ? y_q + 10'd1 : 10'd0;
    x_last = (x_q == XLast);
    y_last = (y_q == YLast);

    // An HD low must land exactly one cycle after the last column, and nowhere else.
    line_err  = (state_q != StSearch) && (hd_low != x_last);
    frame_err = (state_q != StSearch) && !line_err && hd_low && (iVD ? y_last : !y_last);
    frame_ok  = !line_err && hd_low && !iVD && y_last;

    state_d = state_q;
    unique case (state_q)
      StSearch:  if (hd_low && !iVD) state_d = StAcquire;
      StAcquire: begin
        if (line_err)      state_d = StSearch;
        else if (frame_ok) state_d = StLocked;
      end
      StLocked: begin
        if (line_err)       state_d = StSearch;
        else if (frame_err) state_d = StAcquire;
      end
      default: state_d = StSearch;
    endcase

    act      = (state_q == StLocked) && (x_d >= XAct0) && (x_d < XAct1)
               && (y_d >= YAct0) && (y_d < YAct1);
    first_px = act && (x_d == XAct0) && (y_d == YAct0);
    last_px  = act && (x_d == XAct1 - 11'd1) && (y_d == YAct1 - 10'd1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= StSearch;
      x_q         <= '0;
      y_q         <= '0;
      oPixValid   <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oPixel      <= '0;
      oFrameStart <= 1'b0;
      oFrameEnd   <= 1'b0;
      oLocked     <= 1'b0;
      oLineErr    <= 1'b0;
      oFrameErr   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      oPixValid   <= act;
      oX          <= act ? 10'(x_d - XAct0) : 10'd0;
      oY          <= act ? 9'(y_d - YAct0) : 9'd0;
      oPixel      <= act ? pix : 24'd0;
      oFrameStart <= first_px;
      oFrameEnd   <= last_px;
      oLocked     <= (state_d == StLocked);
      oLineErr    <= line_err;
      oFrameErr   <= frame_err;
    end
  end

`ifdef MTL_RX_CHECKSUM_EN
  logic [31:0] acc_q;

  // The accumulator already includes the last pixel when oFrameEnd is high, so copy it then.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      acc_q     <= '0;
      oFrameSum <= '0;
    end else begin
      if (act) acc_q <= first_px ? {8'd0, pix} : acc_q + {8'd0, pix};
      if (oFrameEnd) oFrameSum <= acc_q;
    end
  end
`endif

endmodule

// File: tb/tb_mtl_video_receiver.sv
// Directed bench for mtl_video_receiver using a reduced 40x20 timing so frames stay short.
module tb_mtl_video_receiver;

  localparam int H    = 40;
  localparam int V    = 20;
  localparam int HB   = 6;
  localparam int HF   = 10;
  localparam int VB   = 3;
  localparam int VF   = 4;
  localparam int NPIX = (H - HB - HF) * (V - VB - VF);

  logic        clk = 1'b0;
  logic        iRST, iHD, iVD;
  logic [7:0]  iLCD_R, iLCD_G, iLCD_B;
  logic        oPixValid, oFrameStart, oFrameEnd, oLocked, oLineErr, oFrameErr;
  logic [9:0]  oX;
  logic [8:0]  oY;
  logic [23:0] oPixel;
`ifdef MTL_RX_CHECKSUM_EN
  logic [31:0] oFrameSum;
`endif

  mtl_video_receiver #(
    .H_LINE (H),
    .V_LINE (V),
    .H_BLANK(HB),
    .H_FRONT(HF),
    .V_BLANK(VB),
    .V_FRONT(VF)
  ) dut (
    .iCLK       (clk),
    .iRST       (iRST),
    .iHD        (iHD),
    .iVD        (iVD),
    .iLCD_R     (iLCD_R),
    .iLCD_G     (iLCD_G),
    .iLCD_B     (iLCD_B),
    .oPixValid  (oPixValid),
    .oX         (oX),
    .oY         (oY),
    .oPixel     (oPixel),
    .oFrameStart(oFrameStart),
    .oFrameEnd  (oFrameEnd),
    .oLocked    (oLocked),
    .oLineErr   (oLineErr),
`ifdef MTL_RX_CHECKSUM_EN
    .oFrameErr  (oFrameErr),
    .oFrameSum  (oFrameSum)
`else
    .oFrameErr  (oFrameErr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_valid, n_fs, n_fe, n_lerr, n_ferr, n_lock, n_bad, rst_bad, rst_seen;
  bit pat_mode = 1'b0;
  bit chk_en = 1'b0;
  bit chk_q = 1'b0;
  bit rst_q = 1'b0;
  logic [23:0] cpix = 24'h123456;
  int rst_line = -1;
  int rst_x = -1;
  logic        e_valid, e_fs, e_fe;
  logic [9:0]  e_x;
  logic [8:0]  e_y;
  logic [23:0] e_pix;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clr_tally();
    n_valid = 0; n_fs = 0; n_fe = 0; n_lerr = 0; n_ferr = 0;
    n_lock = 0; n_bad = 0; rst_bad = 0; rst_seen = 0;
  endtask

  // One pixel clock: tally the outputs of the previous cycle, then drive this cycle's inputs.
  task automatic step(input bit hd, input bit vd, input int x, input int y);
    logic [23:0] pix;
    bit act;
    @(negedge clk);
    n_valid += int'(oPixValid);
    n_fs    += int'(oFrameStart);
    n_fe    += int'(oFrameEnd);
    n_lerr  += int'(oLineErr);
    n_ferr  += int'(oFrameErr);
    n_lock  += int'(oLocked);
    if (chk_q && ({oPixValid, oX, oY, oPixel, oFrameStart, oFrameEnd}
                  !== {e_valid, e_x, e_y, e_pix, e_fs, e_fe})) n_bad++;
    if (rst_q) begin
      rst_seen++;
      if ({oPixValid, oX, oY, oPixel, oFrameStart, oFrameEnd, oLocked, oLineErr, oFrameErr}
          != '0) rst_bad++;
    end
    pix = pat_mode ? {x[7:0], y[7:0], 8'hA5} : cpix;
    iHD = hd;
    iVD = vd;
    {iLCD_R, iLCD_G, iLCD_B} = pix;
    iRST = (y == rst_line) && (x == rst_x);
    rst_q = iRST;
    chk_q = chk_en;
    act = (x >= HB) && (x < H - HF) && (y >= VB) && (y < V - VF);
    e_valid = act;
    e_x   = act ? 10'(x - HB) : 10'd0;
    e_y   = act ? 9'(y - VB) : 9'd0;
    e_pix = act ? pix : 24'd0;
    e_fs  = act && (x == HB) && (y == VB);
    e_fe  = act && (x == H - HF - 1) && (y == V - VF - 1);
  endtask

  task automatic drive_frame(input int nlines, input int short_line);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? H - 1 : H;
      for (int xx = 0; xx < len; xx++) step(xx != 0, l != 0, xx, l);
    end
  endtask

  initial begin
    iRST = 1'b1; iHD = 1'b1; iVD = 1'b1;
    iLCD_R = 8'd0; iLCD_G = 8'd0; iLCD_B = 8'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", oPixValid, 0);
    check_eq("rst_locked", oLocked, 0);
    check_eq("rst_pixel", oPixel, 0);
    check_eq("rst_errs", {oLineErr, oFrameErr}, 0);
`ifdef MTL_RX_CHECKSUM_EN
    check_eq("rst_sum", oFrameSum, 0);
    cpix = 24'h000001;
`endif

    // Nominal frames: lock at start of frame 2, full active count, no errors.
    clr_tally(); drive_frame(V, -1);
    check_eq("f1_lock_cycles", n_lock, 0);
    check_eq("f1_locked", oLocked, 0);
    clr_tally(); drive_frame(V, -1);
    check_eq("f2_lock_cycles", n_lock, H * V - 1);
    check_eq("f2_valid", n_valid, NPIX);
    check_eq("f2_fs_fe", {n_fs[7:0], n_fe[7:0]}, {8'd1, 8'd1});
    check_eq("f2_errs", n_lerr + n_ferr, 0);
`ifdef MTL_RX_CHECKSUM_EN
    check_eq("f2_sum", oFrameSum, NPIX);
`endif

    // Coordinate-coded pixels checked cycle by cycle.
    clr_tally(); pat_mode = 1'b1; chk_en = 1'b1;
    drive_frame(V, -1);
    pat_mode = 1'b0; chk_en = 1'b0;
    check_eq("f3_pix_stream", n_bad, 0);
    check_eq("f3_valid", n_valid, NPIX);
    check_eq("f3_fs_fe", {n_fs[7:0], n_fe[7:0]}, {8'd1, 8'd1});
    check_eq("f3_errs", n_lerr + n_ferr, 0);

    // Short line 5: line error at the early HD low, then two frames to relock.
    clr_tally(); drive_frame(V, 5);
    check_eq("short_lerr", n_lerr, 1);
    check_eq("short_ferr", n_ferr, 0);
    check_eq("short_lock_cycles", n_lock, 6 * H);
    check_eq("short_no_fe", n_fe, 0);
    check_eq("short_locked", oLocked, 0);
    clr_tally(); drive_frame(V, -1);
    check_eq("relock_acq_lock", n_lock, 0);
    clr_tally(); drive_frame(V, -1);
    check_eq("relock_lock_cycles", n_lock, H * V - 1);
    check_eq("relock_errs", n_lerr + n_ferr, 0);

    // Truncated frame: VD low one line early gives a frame error and drops to ACQUIRE.
    clr_tally(); drive_frame(V - 1, -1);
    clr_tally(); drive_frame(V, -1);
    check_eq("trunc_ferr", n_ferr, 1);
    check_eq("trunc_lerr", n_lerr, 0);
    check_eq("trunc_lock_cycles", n_lock, 1);
    check_eq("trunc_no_fe", n_fe, 0);
    check_eq("trunc_valid", n_valid, 0);
    clr_tally(); drive_frame(V, -1);
    check_eq("trunc_relock_one_frame", n_lock, H * V - 1);

    // One-cycle reset inside the active area while locked.
    clr_tally(); rst_line = 8; rst_x = 20;
    drive_frame(V, -1);
    rst_line = -1; rst_x = -1;
    check_eq("midrst_seen", rst_seen, 1);
    check_eq("midrst_outputs_zero", rst_bad, 0);
    check_eq("midrst_lock_cycles", n_lock, 8 * H + 21);
    clr_tally(); drive_frame(V, -1);
    check_eq("midrst_search_acq", n_lock, 0);
    clr_tally(); drive_frame(V, -1);
    check_eq("midrst_relock", n_lock, H * V - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
